instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Program-loading block that runs the decode path in reverse. It accepts one mnemonic-level instruction request per handshake, packs it into the 32-bit instruction word that the control decoder consumes, and writes the word into instruction memory at consecutive addresses.
- It sits between the debug/UART program loader and instruction memory.
- It validates every request. The first illegal request stops the load with an error code.

Parameters:
- AW, 10, instruction memory address width
- DEPTH, 1024, number of writable words (must be ≤ 2^AW)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches base_addr and begins a load
- base_addr  in  AW  first write address
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_mnem  in  4  0-3 ARITH op0-3, 4 MOV, 5 LDR, 6 LDG, 7 LDB, 8 B, 9 BL, 10 CMP, 11 RET, 12 STR, 13 STG, 14 STB, 15 illegal
- in_rd / in_rn / in_rm  in  5 each  register indices
- in_use_imm  in  1  immediate form (for B: 1 = backward)
- in_imm  in  27  immediate value or branch offset magnitude
- in_last  in  1  final instruction of the program
- im_we  out  1  memory write strobe
- im_addr  out  AW  write address
- im_wdata  out  32  encoded word
- im_rdata  in  32  memory read data (used only with readback)
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error flag
- err_code  out  3  error code: 0 none, 1 illegal mnemonic, 2 immediate out of range, 3 address overflow, 4 readback mismatch
- count  out  AW  words written in the current load

Behaviour:
- Reset is asynchronous and active-high. On reset, every output is 0 and the state is IDLE. Reset mid-load abandons the load; memory contents are not restored.
- Word format:
  - [31:30] tipo, [29:28] op, [27] Inm.
  - [26:22] rd, [21:17] rn.
  - [16:0] is imm17 when Inm=1. When Inm=0, rm occupies [16:12] and [11:0] are 0.
- Mnemonic mapping to {tipo, op}:
  - 0-3 → {00, mnem[1:0]}
  - 4-7 → {01, mnem-4}
  - 8 → {10, 00}, 9 → {10, 01}, 10 → {10, 10}
  - 11-14 → {11, mnem-11}
- Field rules per class:
  - B/BL: [26:0] = in_imm. Inm = in_use_imm for B; Inm = 0 for BL.
  - RET: [27:0] = 0.
  - CMP: rd field = 0.
  - All other classes follow the word format above.
- Immediate range check: for non-branch classes with in_use_imm=1, in_imm[26:17] must be 0; otherwise error 2.
- State machine:
  - IDLE: busy=0, in_ready=0. start → RUN, im_addr=base_addr, count=0. A start pulse while not in IDLE or ERR is ignored.
  - RUN: in_ready=1. On in_valid && in_ready:
    - illegal mnemonic → ERR (code 1);
    - range fail → ERR (code 2);
    - otherwise register the word into im_wdata and go to WRITE.
  - WRITE: im_we=1 for exactly one cycle, then count+1.
    - If in_last → DONE.
    - Else if im_addr - base_addr = DEPTH-1 → ERR (code 3).
    - Else im_addr+1 and return to RUN.
  - DONE: done=1 for one cycle, then IDLE. im_addr and count hold their final values.
  - ERR: err=1 and err_code held, in_ready=0. start clears err and err_code and begins a new load.
- Latency and throughput: the im_we strobe is asserted in the cycle after acceptance. in_ready is low in every state except RUN, so peak throughput is one word per 2 cycles.
- im_addr wraps modulo 2^AW. No write is issued for a rejected request.

Optional Feature:
- Macro INSTR_ENC_READBACK_EN.
- Defined: WRITE → VERIFY. In VERIFY the block waits one cycle for synchronous memory read latency at im_addr, then compares im_rdata with im_wdata. On a mismatch → ERR (code 4); on a match, the normal post-WRITE transitions apply. Throughput becomes one word per 3 cycles.
- Undefined: the VERIFY state is absent, im_rdata is unused, and code 4 never occurs.

Test Plan:
- start with base_addr=0x010; MOV rd=3, use_imm=1, imm=5, last=1 → im_we at 0x010, im_wdata=0x48C0_0005, done pulse, count=1.
- Back-to-back requests ARITH0 rd1 rn2 rm3 reg; B use_imm=1 imm=8; RET last → writes 0x0044_3000, 0x8800_0008, 0xC000_0000 at consecutive addresses; in_ready is low in every WRITE cycle.
- STB rd4 rn5 reg, then mnem=15 → one write of 0xF10A_0000, then err=1, err_code=1, no second write; a new start clears err.
- LDR use_imm=1 imm=0x20000 → err_code=2, im_we never asserted.
- DEPTH=4, four non-last requests → fourth write occurs, then err_code=3.
- Reset asserted during WRITE → all outputs are 0 immediately (asynchronous). With INSTR_ENC_READBACK_EN and the memory returning a corrupted word → err_code=4.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs mnemonic-level requests into 32-bit instruction words and writes them to consecutive memory addresses.
// Define INSTR_ENC_READBACK_EN to verify each written word through im_rdata.
module instr_encoder #(
  parameter int AW = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_mnem,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rn,
  input  logic [4:0]    in_rm,
  input  logic          in_use_imm,
  input  logic [26:0]   in_imm,
  input  logic          in_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  input  logic [31:0]   im_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    err_code,
  output logic [AW-1:0] count
);
`ifdef INSTR_ENC_READBACK_EN
  typedef enum logic [2:0] {IDLE, RUN, WRITE, VERIFY, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, ERR} state_t;
`endif
  state_t state, nxt;
  logic [AW-1:0] base_q;
  logic last_q, acc, illegal, range_bad, branch, at_end, post, rb_bad;
  logic [3:0] m11, tipo_op;
  logic [31:0] word;
  state_t post_nxt;
  assign acc = in_valid && in_ready;
  assign illegal = in_mnem == 4'd15;
  assign branch = in_mnem == 4'd8 || in_mnem == 4'd9;
  assign range_bad = !branch && in_use_imm && |in_imm[26:17];
  assign m11 = in_mnem - 4'd11;
  // codes 0-10 already equal {tipo, op}; 11-14 restart op at 0 in class 11
  assign tipo_op = in_mnem < 4'd11 ? in_mnem : {2'b11, m11[1:0]};
  assign word = branch ? {tipo_op, in_mnem == 4'd8 && in_use_imm, in_imm}
              : in_mnem == 4'd11 ? {tipo_op, 28'd0}
              : {tipo_op, in_use_imm, in_mnem == 4'd10 ? 5'd0 : in_rd, in_rn,
                 in_use_imm ? in_imm[16:0] : {in_rm, 12'd0}};
  assign at_end = (im_addr - base_q) == AW'(DEPTH - 1);
  assign post_nxt = last_q ? DONE : at_end ? ERR : RUN;
`ifdef INSTR_ENC_READBACK_EN
  assign post = state == VERIFY && im_rdata == im_wdata;
  assign rb_bad = state == VERIFY && im_rdata != im_wdata;
`else
  logic unused_rdata;
  assign unused_rdata = ^im_rdata;
  assign post = state == WRITE;
  assign rb_bad = 1'b0;
`endif
  assign in_ready = state == RUN;
  assign im_we = state == WRITE;
  assign done = state == DONE;
  assign err = state == ERR;
`ifdef INSTR_ENC_READBACK_EN
  assign busy = state == RUN || state == WRITE || state == VERIFY;
`else
  assign busy = state == RUN || state == WRITE;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? RUN : IDLE;
      RUN:     nxt = !acc ? RUN : (illegal || range_bad) ? ERR : WRITE;
`ifdef INSTR_ENC_READBACK_EN
      WRITE:   nxt = VERIFY;
      VERIFY:  nxt = rb_bad ? ERR : post_nxt;
`else
      WRITE:   nxt = post_nxt;
`endif
      DONE:    nxt = IDLE;
      ERR:     nxt = start ? RUN : ERR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base_q <= '0;
      im_addr <= '0;
      count <= '0;
      im_wdata <= '0;
      err_code <= '0;
      last_q <= 1'b0;
    end else begin
      state <= nxt;
      if (start && (state == IDLE || state == ERR)) begin
        base_q <= base_addr;
        im_addr <= base_addr;
        count <= '0;
        err_code <= '0;
      end
      if (acc) begin
        im_wdata <= word;
        last_q <= in_last;
        err_code <= illegal ? 3'd1 : range_bad ? 3'd2 : err_code;
      end
      if (state == WRITE) count <= count + 1'b1;
      if (post && !last_q) begin
        if (at_end) err_code <= 3'd3;
        else im_addr <= im_addr + 1'b1;
      end
      if (rb_bad) err_code <= 3'd4;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scoreboard bench for instr_encoder with a spec-level reference model.
module tb_instr_encoder;
  localparam int AW = 10;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, in_use_imm = 0, in_last = 0;
  logic [AW-1:0] base_addr = '0;
  logic [3:0] in_mnem = '0;
  logic [4:0] in_rd = '0, in_rn = '0, in_rm = '0;
  logic [26:0] in_imm = '0;
  logic [31:0] im_rdata = '0;
  logic in_ready, im_we, busy, done, err;
  logic [AW-1:0] im_addr, count;
  logic [31:0] im_wdata;
  logic [2:0] err_code;

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_use_imm(in_use_imm),
    .in_imm(in_imm), .in_last(in_last), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .im_rdata(im_rdata), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  // write-first synchronous memory so readback builds see the fresh word
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (im_we) mem[im_addr] <= im_wdata;
    im_rdata <= im_we ? im_wdata : mem[im_addr];
  end

  typedef struct { logic [AW-1:0] a; logic [31:0] w; } wr_t;
  wr_t wq[$];
  int evq[$];
  wr_t e;
  int n_cmp = 0, n_bad = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic bit [31:0] model_word(int m, int rd, int rn, int rm, int ui, int imm);
    bit [31:0] tipo, op, w;
    tipo = m < 4 ? 0 : m < 8 ? 1 : m < 11 ? 2 : 3;
    op = m < 4 ? m : m < 8 ? m - 4 : m < 11 ? m - 8 : m - 11;
    w = tipo * 32'h4000_0000 + op * 32'h1000_0000;
    if (m == 8 || m == 9)
      w = w + ((m == 8 && ui != 0) ? 32'h0800_0000 : 0) + (imm % (1 << 27));
    else if (m != 11)
      w = w + (ui != 0 ? 32'h0800_0000 : 0) + (m == 10 ? 0 : rd) * (1 << 22) + rn * (1 << 17)
            + (ui != 0 ? imm % (1 << 17) : rm * (1 << 12));
    return w;
  endfunction

  logic err_d = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (im_we) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", im_addr, e.a);
          chk("wr_data", im_wdata, e.w);
        end
        chk("in_ready_during_write", in_ready, 0);
      end
      if (done) begin
        if (evq.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_event", 0, evq.pop_front());
      end
      if (err && !err_d) begin
        if (evq.size() == 0) chk("unexpected_err", 1, 0);
        else chk("err_code", err_code, evq.pop_front());
      end
    end
    err_d = err;
  end

  int exp_base, idx, exp_cnt, exp_code;
  bit ended;

  task automatic begin_load(int base);
    @(negedge clk);
    start = 1; base_addr = AW'(base);
    @(negedge clk);
    start = 0;
    chk("start_clears_err", {err, err_code}, 0);
    chk("busy_after_start", busy, 1);
    exp_base = base; idx = 0; exp_cnt = 0; ended = 0; exp_code = 0;
  endtask

  task automatic req(int m, int rd, int rn, int rm, int ui, int imm, bit last);
    int n = 0;
    bit nonbr;
    if (ended) return;
    nonbr = !(m == 8 || m == 9);
    if (m == 15) begin evq.push_back(1); exp_code = 1; ended = 1; end
    else if (nonbr && ui != 0 && (imm % (1 << 27)) >= (1 << 17)) begin evq.push_back(2); exp_code = 2; ended = 1; end
    else begin
      wq.push_back('{a: AW'((exp_base + idx) % (1 << AW)), w: model_word(m, rd, rn, rm, ui, imm)});
      exp_cnt++;
      if (last) begin evq.push_back(0); ended = 1; end
      else if (idx == DEPTH - 1) begin evq.push_back(3); exp_code = 3; ended = 1; end
    end
    @(negedge clk);
    in_valid = 1; in_mnem = 4'(m); in_rd = 5'(rd); in_rn = 5'(rn); in_rm = 5'(rm);
    in_use_imm = ui[0]; in_imm = 27'(imm); in_last = last;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin chk("ready_timeout", 1, 0); ended = 1; end
    else @(posedge clk);
    #1 in_valid = 0;
    idx++;
  endtask

  task automatic end_load();
    int n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    if (n == 20) chk("busy_timeout", 1, 0);
    repeat (2) @(negedge clk);
    chk("count", count, exp_cnt);
    chk("scoreboard_drained", wq.size() + evq.size(), 0);
    chk("err_flag", {err, err_code}, exp_code != 0 ? {1'b1, 3'(exp_code)} : 4'd0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {in_ready, im_we, im_addr, im_wdata, busy, done, err, err_code, count}, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("idle_ready_low", {in_ready, busy}, 0);
    // single MOV load
    begin_load('h010);
    req(4, 3, 0, 0, 1, 5, 1);
    end_load();
    chk("final_addr", im_addr, 'h010);
    // back-to-back ARITH0, B backward, RET
    begin_load('h100);
    req(0, 1, 2, 3, 0, 0, 0);
    req(8, 0, 0, 0, 1, 8, 0);
    req(11, 0, 0, 0, 0, 0, 1);
    end_load();
    // STB followed by an illegal mnemonic
    begin_load('h020);
    req(14, 4, 5, 0, 0, 0, 0);
    req(15, 0, 0, 0, 0, 0, 1);
    end_load();
    // immediate out of range
    begin_load('h030);
    req(5, 1, 2, 0, 1, 'h20000, 1);
    end_load();
    // address overflow with wrap through the top of memory
    begin_load((1 << AW) - 3);
    for (int i = 0; i < DEPTH + 2; i++) req(i % 8, i, i + 1, i + 2, 0, 0, 0);
    end_load();
    // randomized programs
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, DEPTH + 2);
      begin_load($urandom_range(0, (1 << AW) - 1));
      for (int i = 0; i < len; i++) begin
        int m = $urandom_range(0, 14);
        int ui = $urandom_range(0, 1);
        int imm = ($urandom_range(0, 7) == 0 || m == 8 || m == 9) ? int'($urandom % (1 << 27)) : int'($urandom % (1 << 17));
        if ($urandom_range(0, 24) == 0) m = 15;
        req(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), ui, imm, i == len - 1);
      end
      end_load();
    end
    // asynchronous reset while a write is in progress
    begin_load('h055);
    req(1, 7, 8, 9, 0, 0, 1);
    chk("in_write_before_reset", im_we, 1);
    rst = 1;
    #1;
    chk("async_reset_outputs", {in_ready, im_we, im_addr, im_wdata, busy, done, err, err_code, count}, 0);
    wq.delete();
    evq.delete();
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {busy, done, err, im_we}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
